multicycle_controller: RTL

Parametrised multi-cycle main control unit for the RV32I core. It replaces one-cycle opcode decoding with a FETCH/DECODE/EXEC/MEM/WB state machine that shares one ALU and one memory port across cycles, and waits on a memory ready handshake. It adds JAL/JALR support, illegal-opcode and memory-timeout traps, and a retire pulse. It sits between the instruction register (opcode source) and the multi-cycle datapath muxes, register file, PC and memory interface.

---
 rtl/multicycle_controller.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over a shared ALU
// and memory port, with a mem_ready handshake, JAL/JALR, and illegal-opcode/timeout traps.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter bit          JUMP_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       alu_zero,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       instr_done,
    output logic       trap,
    output logic       trap_cause
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpBr   = 7'b1100011;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;

    state_e          state_q, state_d;
    logic [6:0]      op_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cause_q, cause_d;
    logic            waiting, timeout;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OpR) || (op == OpI) || (op == OpLw) || (op == OpSw) || (op == OpBr) ||
               (JUMP_EN && ((op == OpJal) || (op == OpJalr)));
    endfunction

    assign waiting = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
    // Trap on the wait cycle that would bring the counter up to the limit.
    assign timeout = (MEM_TIMEOUT != 0) && waiting && (cnt_q == CntW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                    cause_d = 1'b1;
                end
            end
            StDecode: begin
                if (is_legal(opcode)) begin
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                    cause_d = 1'b0;
                end
            end
            StExec: begin
                case (op_q)
                    OpR, OpI:   state_d = StWb;
                    OpLw, OpSw: state_d = StMem;
                    default:    state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (op_q == OpSw) ? StFetch : StWb;
                end else if (timeout) begin
                    state_d = StTrap;
                    cause_d = 1'b1;
                end
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            op_q    <= '0;
            cnt_q   <= '0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            if (state_q == StDecode) begin
                op_q <= opcode;
            end
        end
    end

    // Outputs are gated by reset so every strobe drops without waiting for a clock edge.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        instr_done = 1'b0;
        trap       = 1'b0;
        trap_cause = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b10;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StExec, StMem, StWb: begin
                    case (op_q)
                        OpR: begin
                            alu_src_a = 1'b1;
                            alu_op    = 2'b10;
                        end
                        OpI: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b01;
                            alu_op    = 2'b11;
                        end
                        OpLw, OpSw: begin
                            if (state_q != StWb) begin
                                alu_src_a = 1'b1;
                                alu_src_b = 2'b01;
                            end
                        end
                        OpBr: begin
                            alu_src_a  = 1'b1;
                            alu_op     = 2'b01;
                            pc_src     = 2'b01;
                            pc_write   = alu_zero;
                            instr_done = 1'b1;
                        end
                        OpJal, OpJalr: begin
                            pc_src     = (op_q == OpJal) ? 2'b01 : 2'b10;
                            pc_write   = 1'b1;
                            reg_write  = 1'b1;
                            wb_sel     = 2'b10;
                            instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                    if (state_q == StMem) begin
                        mem_req    = 1'b1;
                        mem_we     = (op_q == OpSw);
                        instr_done = (op_q == OpSw) && mem_ready;
                    end
                    if (state_q == StWb) begin
                        reg_write  = 1'b1;
                        wb_sel     = (op_q == OpLw) ? 2'b01 : 2'b00;
                        instr_done = 1'b1;
                    end
                end
                StTrap: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: ;
            endcase
        end
    end

endmodule
